// File: rtl/port_arbiter.sv
// port_arbiter: two-master (CPU / host) arbiter and sequencer for the 16-bit port I/O bus.
// Optional macro PORT_ARB_TIMEOUT_EN aborts a BUS transfer after TIMEOUT_CYCLES cycles without portready.
module port_arbiter #(
    parameter int WORD_SIZE = 16
`ifdef PORT_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                 clk,
    input  logic                 do_reset_n,
    input  logic [WORD_SIZE-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0] cpu_val,
    input  logic                 cpu_get,
    input  logic                 cpu_set,
    output logic [WORD_SIZE-1:0] cpu_rdata,
    output logic                 cpu_done,
    output logic                 cpu_err,
    input  logic [WORD_SIZE-1:0] host_addr,
    input  logic [WORD_SIZE-1:0] host_val,
    input  logic                 host_get,
    input  logic                 host_set,
    output logic [WORD_SIZE-1:0] host_rdata,
    output logic                 host_done,
    output logic                 host_err,
    output logic [WORD_SIZE-1:0] portaddr,
    output logic [WORD_SIZE-1:0] portval,
    output logic                 portget,
    output logic                 portset,
    input  logic [WORD_SIZE-1:0] portout,
    input  logic                 portready,
    output logic                 grant,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    state_t               r_state;
    logic                 r_lastGrant;
    logic                 r_grant;
    logic [WORD_SIZE-1:0] r_portaddr;
    logic [WORD_SIZE-1:0] r_portval;
    logic                 r_portget;
    logic                 r_portset;
    logic [WORD_SIZE-1:0] r_cpuRdata;
    logic [WORD_SIZE-1:0] r_hostRdata;
    logic                 r_cpuDone;
    logic                 r_hostDone;

`ifdef PORT_ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0]           r_timer;
    logic                 r_cpuErr;
    logic                 r_hostErr;
`endif

    logic                 w_cpuReq;
    logic                 w_hostReq;
    logic                 w_pickHost;
    logic                 w_pickSet;
    logic [WORD_SIZE-1:0] w_pickAddr;
    logic [WORD_SIZE-1:0] w_pickVal;

    // On a tie the master that did not win last time gets the bus.
    assign w_cpuReq   = cpu_get | cpu_set;
    assign w_hostReq  = host_get | host_set;
    assign w_pickHost = w_hostReq & (~w_cpuReq | ~r_lastGrant);
    assign w_pickSet  = w_pickHost ? host_set  : cpu_set;
    assign w_pickAddr = w_pickHost ? host_addr : cpu_addr;
    assign w_pickVal  = w_pickHost ? host_val  : cpu_val;

    always_ff @(posedge clk or negedge do_reset_n) begin
        if (!do_reset_n) begin
            r_state     <= IDLE;
            r_lastGrant <= 1'b1;
            r_grant     <= 1'b0;
            r_portaddr  <= '0;
            r_portval   <= '0;
            r_portget   <= 1'b0;
            r_portset   <= 1'b0;
            r_cpuRdata  <= '0;
            r_hostRdata <= '0;
            r_cpuDone   <= 1'b0;
            r_hostDone  <= 1'b0;
`ifdef PORT_ARB_TIMEOUT_EN
            r_timer     <= 8'd0;
            r_cpuErr    <= 1'b0;
            r_hostErr   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cpuReq || w_hostReq) begin
                        r_state     <= BUS;
                        r_grant     <= w_pickHost;
                        r_lastGrant <= w_pickHost;
                        r_portaddr  <= w_pickAddr;
                        r_portval   <= w_pickVal;
                        r_portset   <= w_pickSet;
                        r_portget   <= ~w_pickSet;
`ifdef PORT_ARB_TIMEOUT_EN
                        r_timer     <= 8'd0;
`endif
                    end
                end
                BUS: begin
                    if (portready) begin
                        r_state   <= RESP;
                        r_portget <= 1'b0;
                        r_portset <= 1'b0;
                        if (r_grant) begin
                            r_hostDone <= 1'b1;
                            if (r_portget) begin
                                r_hostRdata <= portout;
                            end
                        end else begin
                            r_cpuDone <= 1'b1;
                            if (r_portget) begin
                                r_cpuRdata <= portout;
                            end
                        end
                    end
`ifdef PORT_ARB_TIMEOUT_EN
                    else if (r_timer == TIMEOUT_LIMIT) begin
                        r_state   <= RESP;
                        r_portget <= 1'b0;
                        r_portset <= 1'b0;
                        if (r_grant) begin
                            r_hostRdata <= '1;
                            r_hostDone  <= 1'b1;
                            r_hostErr   <= 1'b1;
                        end else begin
                            r_cpuRdata <= '1;
                            r_cpuDone  <= 1'b1;
                            r_cpuErr   <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
`endif
                end
                RESP: begin
                    r_state    <= IDLE;
                    r_cpuDone  <= 1'b0;
                    r_hostDone <= 1'b0;
`ifdef PORT_ARB_TIMEOUT_EN
                    r_cpuErr   <= 1'b0;
                    r_hostErr  <= 1'b0;
`endif
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign portaddr   = r_portaddr;
    assign portval    = r_portval;
    assign portget    = r_portget;
    assign portset    = r_portset;
    assign grant      = r_grant;
    assign busy       = (r_state != IDLE);
    assign cpu_rdata  = r_cpuRdata;
    assign host_rdata = r_hostRdata;
    assign cpu_done   = r_cpuDone;
    assign host_done  = r_hostDone;

`ifdef PORT_ARB_TIMEOUT_EN
    assign cpu_err    = r_cpuErr;
    assign host_err   = r_hostErr;
`else
    assign cpu_err    = 1'b0;
    assign host_err   = 1'b0;
`endif

endmodule

// File: tb/tb_port_arbiter.sv
// tb_port_arbiter: randomized scoreboard bench for port_arbiter with a transaction-level arbitration model.
// Honors PORT_ARB_TIMEOUT_EN (timeout build runs with TIMEOUT_CYCLES=4).
module tb_port_arbiter;

    logic        clk = 1'b0;
    logic        do_reset_n = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_val = '0, host_addr = '0, host_val = '0;
    logic        cpu_get = 1'b0, cpu_set = 1'b0, host_get = 1'b0, host_set = 1'b0;
    logic [15:0] cpu_rdata, host_rdata, portaddr, portval;
    logic        cpu_done, cpu_err, host_done, host_err;
    logic        portget, portset, grant, busy;
    logic [15:0] portout;
    logic        portready;

    always #5 clk = ~clk;

    port_arbiter #(
        .WORD_SIZE(16)
`ifdef PORT_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(4)
`endif
    ) dut (
        .clk(clk), .do_reset_n(do_reset_n),
        .cpu_addr(cpu_addr), .cpu_val(cpu_val), .cpu_get(cpu_get), .cpu_set(cpu_set),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err),
        .host_addr(host_addr), .host_val(host_val), .host_get(host_get), .host_set(host_set),
        .host_rdata(host_rdata), .host_done(host_done), .host_err(host_err),
        .portaddr(portaddr), .portval(portval), .portget(portget), .portset(portset),
        .portout(portout), .portready(portready), .grant(grant), .busy(busy)
    );

    typedef struct {
        bit          host;
        bit          get;
        bit          set;
        logic [15:0] addr;
        logic [15:0] val;
        bit          tmo;
    } xfer_t;

    xfer_t       cpuList[$], hostList[$], busQ[$], doneQ[$];
    logic [15:0] retQ[$];
    logic [15:0] mRdata [2];
    bit          mLastGrant = 1'b1;
    int          checks = 0, errors = 0;
    int          lastLat [2];
    bit          periphEn = 1'b1;
    int          forcedWait = -1;
    bit          useForcedData = 1'b0;
    logic [15:0] forcedData = '0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: event missing or unexpected", name);
    endtask

    function automatic xfer_t mk(bit host, bit get, bit set, logic [15:0] a, logic [15:0] v, bit tmo);
        xfer_t t;
        t.host = host; t.get = get; t.set = set; t.addr = a; t.val = v; t.tmo = tmo;
        return t;
    endfunction

    function automatic xfer_t mkRandom(bit host);
        int dir;
        dir = $urandom_range(0, 2);
        return mk(host, dir != 1, dir != 0, 16'($urandom), 16'($urandom), 1'b0);
    endfunction

    task automatic applyStimulus(input bit isHost, input xfer_t t);
        if (isHost) begin
            host_addr = t.addr; host_val = t.val; host_get = t.get; host_set = t.set;
        end else begin
            cpu_addr = t.addr; cpu_val = t.val; cpu_get = t.get; cpu_set = t.set;
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        do_reset_n = 1'b0;
        repeat (2) @(negedge clk);
        do_reset_n = 1'b1;
        mLastGrant = 1'b1;
        mRdata[0] = '0;
        mRdata[1] = '0;
        busQ.delete(); doneQ.delete(); retQ.delete();
    endtask

    // Each master holds its request until its own done, then renews with the next item or drops.
    task automatic runMaster(input bit isHost);
        xfer_t t;
        int    cyc;
        while ((isHost ? hostList.size() : cpuList.size()) != 0) begin
            t = isHost ? hostList.pop_front() : cpuList.pop_front();
            applyStimulus(isHost, t);
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!(isHost ? host_done : cpu_done) && cyc < 100);
            if (!(isHost ? host_done : cpu_done)) failNow(isHost ? "host done wait" : "cpu done wait");
            lastLat[isHost] = cyc;
        end
        applyStimulus(isHost, mk(isHost, 1'b0, 1'b0, '0, '0, 1'b0));
    endtask

    // Service order: alternate strictly while both have work, CPU/host by last grant, then the leftover master.
    task automatic runRound();
        int ci = 0, hi = 0, cyc = 0;
        bit pickHost;
        while (ci < cpuList.size() || hi < hostList.size()) begin
            if (ci < cpuList.size() && hi < hostList.size()) pickHost = !mLastGrant;
            else pickHost = (hi < hostList.size());
            if (pickHost) begin
                busQ.push_back(hostList[hi]); doneQ.push_back(hostList[hi]); hi++;
            end else begin
                busQ.push_back(cpuList[ci]); doneQ.push_back(cpuList[ci]); ci++;
            end
            mLastGrant = pickHost;
        end
        fork
            runMaster(1'b0);
            runMaster(1'b1);
        join
        while (doneQ.size() != 0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("scoreboard drained", 64'(doneQ.size() + busQ.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Peripheral model: checks each new bus transfer, holds wait states, returns data; random portready noise elsewhere.
    initial begin : peripheral
        xfer_t       e;
        int          w;
        logic [15:0] d;
        portready = 1'b0;
        portout   = '0;
        forever begin
            @(negedge clk);
            if (!periphEn) begin
                portready = 1'b0;
            end else if (do_reset_n && (portget || portset)) begin
                if (busQ.size() == 0) begin
                    failNow("unexpected bus strobe");
                    portready = 1'b0;
                end else begin
                    e = busQ.pop_front();
                    checkOutput("bus start", {portaddr, portval, portget, portset, grant},
                                {e.addr, e.val, !e.set, e.set, e.host});
                    w = (forcedWait >= 0) ? forcedWait : $urandom_range(0, 3);
                    portready = 1'b0;
                    for (int i = 0; i < w; i++) begin
                        @(negedge clk);
                        checkOutput("bus held", {portaddr, portval, portget, portset},
                                    {e.addr, e.val, !e.set, e.set});
                    end
                    d = useForcedData ? forcedData : 16'($urandom);
                    portout   = d;
                    portready = 1'b1;
                    retQ.push_back(d);
                    @(negedge clk);
                    checkOutput("strobes cleared", {portget, portset}, 2'b00);
                    portready = 1'($urandom_range(0, 1));
                    portout   = 16'($urandom);
                end
            end else begin
                portready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin : doneMonitor
        xfer_t       e;
        logic [15:0] expData;
        forever begin
            @(negedge clk);
            if (cpu_done || host_done) begin
                if (cpu_done && host_done) failNow("both done");
                if (doneQ.size() == 0) begin
                    failNow("unexpected done");
                end else begin
                    e = doneQ.pop_front();
                    if (e.tmo) begin
                        expData = 16'hFFFF;
                    end else if (!e.set) begin
                        if (retQ.size() == 0) begin
                            failNow("read data missing");
                            expData = mRdata[e.host];
                        end else begin
                            expData = retQ.pop_front();
                        end
                    end else begin
                        expData = mRdata[e.host];
                        if (retQ.size() != 0) void'(retQ.pop_front());
                    end
                    mRdata[e.host] = expData;
                    checkOutput("done owner", {host_done, grant}, {e.host, e.host});
                    checkOutput("rdata", e.host ? host_rdata : cpu_rdata, expData);
                    checkOutput("err", {e.host ? host_err : cpu_err, e.host ? cpu_err : host_err}, {e.tmo, 1'b0});
                    @(negedge clk);
                    checkOutput("done pulse width", {cpu_done, host_done}, 2'b00);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int  cyc;
        bit  stuck;
        mRdata[0] = '0;
        mRdata[1] = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset bus", {portaddr, portval, portget, portset}, 64'd0);
        checkOutput("reset rdata", {cpu_rdata, host_rdata}, 64'd0);
        checkOutput("reset done/err", {cpu_done, host_done, cpu_err, host_err}, 64'd0);
        checkOutput("reset grant/busy", {grant, busy}, 64'd0);
        do_reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] CPU read 0x0012, 3 BUS cycles");
        forcedWait = 2; useForcedData = 1'b1; forcedData = 16'hBEEF;
        cpuList.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0012, 16'h1234, 1'b0));
        runRound();
        checkOutput("read latency", 64'(lastLat[0]), 64'd4);
        checkOutput("read rdata", cpu_rdata, 16'hBEEF);
        useForcedData = 1'b0;

        $display("[TB] simultaneous write pairs after reset");
        applyReset();
        forcedWait = 0;
        for (int p = 0; p < 2; p++) begin
            cpuList.push_back(mk(1'b0, 1'b0, 1'b1, 16'h0001, 16'h00AA, 1'b0));
            hostList.push_back(mk(1'b1, 1'b0, 1'b1, 16'h0002, 16'h0055, 1'b0));
            runRound();
        end
        cpuList.push_back(mk(1'b0, 1'b0, 1'b1, 16'h0009, 16'h0011, 1'b0));
        runRound();
        checkOutput("min latency", 64'(lastLat[0]), 64'd2);

        $display("[TB] continuous requests from both masters");
        applyReset();
        forcedWait = -1;
        for (int i = 0; i < 3; i++) begin
            cpuList.push_back(mkRandom(1'b0));
            hostList.push_back(mkRandom(1'b1));
        end
        runRound();

        $display("[TB] get and set together");
        cpuList.push_back(mk(1'b0, 1'b1, 1'b1, 16'h0003, 16'h5A5A, 1'b0));
        runRound();

        $display("[TB] random rounds");
        for (int r = 0; r < 25; r++) begin
            int nc, nh;
            nc = $urandom_range(0, 3);
            nh = $urandom_range(0, 3);
            for (int i = 0; i < nc; i++) cpuList.push_back(mkRandom(1'b0));
            for (int i = 0; i < nh; i++) hostList.push_back(mkRandom(1'b1));
            runRound();
        end

        $display("[TB] reset during BUS");
        applyReset();
        periphEn = 1'b0;
        repeat (2) @(negedge clk);
        cpu_get = 1'b1; cpu_addr = 16'h0040;
        host_set = 1'b1; host_addr = 16'h0050; host_val = 16'h0BAD;
        @(negedge clk);
        checkOutput("pre-reset strobe", {portget, portset, grant}, 3'b100);
        @(posedge clk);
        #2 do_reset_n = 1'b0;
        #1;
        checkOutput("async strobe drop", {portget, portset, busy}, 3'b000);
        @(negedge clk);
        cpu_get = 1'b0;
        @(negedge clk);
        do_reset_n = 1'b1;
        mLastGrant = 1'b1;
        mRdata[0] = '0;
        mRdata[1] = '0;
        periphEn = 1'b1;
        forcedWait = 1;
        hostList.push_back(mk(1'b1, 1'b0, 1'b1, 16'h0050, 16'h0BAD, 1'b0));
        runRound();

`ifdef PORT_ARB_TIMEOUT_EN
        $display("[TB] timeout abort");
        applyReset();
        periphEn = 1'b0;
        repeat (2) @(negedge clk);
        doneQ.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0077, 16'h0000, 1'b1));
        host_get = 1'b1; host_addr = 16'h0077;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!host_done && cyc < 50);
        checkOutput("timeout latency", 64'(cyc), 64'd6);
        host_get = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("timeout drained", 64'(doneQ.size()), 64'd0);
        checkOutput("timeout rdata kept", host_rdata, 16'hFFFF);
`else
        $display("[TB] no timeout: BUS waits indefinitely");
        applyReset();
        periphEn = 1'b0;
        repeat (2) @(negedge clk);
        cpu_set = 1'b1; cpu_addr = 16'h0066; cpu_val = 16'h0042;
        @(negedge clk);
        stuck = 1'b1;
        cyc = 0;
        repeat (300) begin
            @(negedge clk);
            if (!busy || cpu_done || host_done) stuck = 1'b0;
        end
        checkOutput("bus stuck without ready", stuck, 1'b1);
        cpu_set = 1'b0;
        applyReset();
        checkOutput("idle after recovery", busy, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
